// File: rtl/mux_nx1_pipe.sv
// Registered N:1 operand mux with enable/range gating and a 2-entry
// valid/ready skid buffer (output register OR plus skid register SK).
module mux_nx1_pipe #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   or_data_reg, sk_data_reg;
  logic               or_err_reg, sk_err_reg;

  logic [WIDTH-1:0]   chan [NUM_IN];
  logic [NUM_IN-1:0]  hit;
  logic [WIDTH-1:0]   beat_data;
  logic               beat_err;

  logic               accept, transfer;
  logic               or_load_beat, or_load_sk, sk_load_beat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
      assign chan[gi] = in_data[gi*WIDTH +: WIDTH];
      assign hit[gi]  = (sel == SEL_W'(gi));
    end
  endgenerate

  // hit is one-hot or zero; no hit means the select is out of range
  always_comb begin
    beat_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      beat_data = beat_data | (chan[k] & {WIDTH{hit[k] & en}});
    end
    beat_err = en & ~(|hit);
  end

  assign in_ready  = (state_reg == ST_EMPTY) || (state_reg == ST_HALF);
  assign out_valid = (state_reg == ST_HALF)  || (state_reg == ST_FULL);
  assign out_data  = or_data_reg;
  assign out_err   = or_err_reg;

  assign accept   = in_valid & in_ready;
  assign transfer = out_valid & out_ready;

  always_comb begin
    state_next   = state_reg;
    or_load_beat = 1'b0;
    or_load_sk   = 1'b0;
    sk_load_beat = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next   = ST_HALF;
          or_load_beat = 1'b1;
        end
      end
      ST_HALF: begin
        if (accept && transfer) begin
          or_load_beat = 1'b1;
        end else if (accept) begin
          state_next   = ST_FULL;
          sk_load_beat = 1'b1;
        end else if (transfer) begin
          state_next   = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (transfer) begin
          state_next = ST_HALF;
          or_load_sk = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // data loads during flush are harmless: the state returns to EMPTY
    if (flush) begin
      state_next = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_EMPTY;
      or_data_reg <= '0;
      or_err_reg  <= 1'b0;
      sk_data_reg <= '0;
      sk_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (or_load_beat) begin
        or_data_reg <= beat_data;
        or_err_reg  <= beat_err;
      end else if (or_load_sk) begin
        or_data_reg <= sk_data_reg;
        or_err_reg  <= sk_err_reg;
      end
      if (sk_load_beat) begin
        sk_data_reg <= beat_data;
        sk_err_reg  <= beat_err;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: a NUM_IN=4 instance for streaming/stall/flush/reset
// and random traffic, and a NUM_IN=3 instance for the out-of-range select.
module tb_mux_nx1_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] in_data;
  logic [1:0]  sel;
  logic        en, in_valid, in_ready, flush, out_err, out_valid, out_ready;
  logic [7:0]  out_data;

  logic [23:0] in_data3;
  logic [1:0]  sel3;
  logic        en3, in_valid3, in_ready3, out_err3, out_valid3;
  logic [7:0]  out_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_nx1_pipe #(.WIDTH(8), .NUM_IN(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_nx1_pipe #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3), .en(en3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(1'b0),
    .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
    .out_ready(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] s, input logic e);
    in_valid = 1'b1;
    sel      = s;
    en       = e;
  endtask

  typedef struct {
    bit         u3;
    logic [1:0] sel;
    logic       en;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[10];

  logic [8:0]  q[$];
  logic [8:0]  exp_beat;
  logic        hold_prev;
  logic [7:0]  hold_data;
  int          accepted, cyc;

  initial begin
    vecs[0] = '{0, 2'd0, 1'b1, 8'h11, 1'b0};
    vecs[1] = '{0, 2'd1, 1'b1, 8'h22, 1'b0};
    vecs[2] = '{0, 2'd2, 1'b1, 8'h33, 1'b0};
    vecs[3] = '{0, 2'd3, 1'b1, 8'h44, 1'b0};
    vecs[4] = '{0, 2'd2, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1, 2'd0, 1'b1, 8'haa, 1'b0};
    vecs[6] = '{1, 2'd2, 1'b1, 8'hcc, 1'b0};
    vecs[7] = '{1, 2'd3, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{1, 2'd3, 1'b0, 8'h00, 1'b0};
    vecs[9] = '{1, 2'd1, 1'b1, 8'hbb, 1'b0};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data = 32'h44332211; sel = '0; en = 1'b0; in_valid = 1'b0;
    in_data3 = 24'hccbbaa; sel3 = '0; en3 = 1'b0; in_valid3 = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_valid3", out_valid3, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven stream, one beat per cycle, result one cycle after accept
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].u3) begin
        in_valid = 1'b0; in_valid3 = 1'b1; sel3 = vecs[i].sel; en3 = vecs[i].en;
      end else begin
        in_valid3 = 1'b0; in_valid = 1'b1; sel = vecs[i].sel; en = vecs[i].en;
      end
      step();
      if (vecs[i].u3) begin
        chk($sformatf("vec%0d_valid3", i), out_valid3, 1);
        chk($sformatf("vec%0d_data3", i), out_data3, vecs[i].exp_data);
        chk($sformatf("vec%0d_err3", i), out_err3, vecs[i].exp_err);
      end else begin
        chk($sformatf("vec%0d_valid", i), out_valid, 1);
        chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
        chk($sformatf("vec%0d_err", i), out_err, vecs[i].exp_err);
        chk($sformatf("vec%0d_ready", i), in_ready, 1);
      end
    end
    in_valid = 1'b0; in_valid3 = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_valid3", out_valid3, 0);

    // stall: A into OR, B into SK, C refused, then all three in order
    out_ready = 1'b0;
    offer(2'd0, 1'b1);
    step();
    chk("stall_a_data", out_data, 8'h11);
    chk("stall_a_ready", in_ready, 1);
    offer(2'd1, 1'b1);
    step();
    chk("stall_full_ready", in_ready, 0);
    chk("stall_full_data", out_data, 8'h11);
    offer(2'd2, 1'b1);
    step();
    chk("stall_c_refused_data", out_data, 8'h11);
    chk("stall_c_refused_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("stall_b_data", out_data, 8'h22);
    chk("stall_b_ready", in_ready, 1);
    step();
    chk("stall_c_data", out_data, 8'h33);
    chk("stall_c_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("stall_end_valid", out_valid, 0);

    // flush while FULL with a beat offered
    out_ready = 1'b0;
    offer(2'd3, 1'b1); step();
    offer(2'd0, 1'b1); step();
    chk("flush_pre_ready", in_ready, 0);
    offer(2'd1, 1'b1); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_valid", out_valid, 0);
    chk("flush_full_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (2) step();
    chk("flush_full_quiet", out_valid, 0);

    // flush while HALF with a beat accepted in the same cycle
    out_ready = 1'b0;
    offer(2'd3, 1'b1); step();
    offer(2'd1, 1'b1); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_half_valid", out_valid, 0);
    out_ready = 1'b1;
    step();
    chk("flush_half_quiet", out_valid, 0);
    offer(2'd2, 1'b1); step();
    in_valid = 1'b0;
    chk("post_flush_data", out_data, 8'h33);
    step();
    chk("post_flush_drain", out_valid, 0);

    // asynchronous reset between edges while FULL
    out_ready = 1'b0;
    offer(2'd3, 1'b1); step();
    offer(2'd2, 1'b1); step();
    in_valid = 1'b0;
    chk("prerst_data", out_data, 8'h44);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_err", out_err, 0);
    chk("midrst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    offer(2'd1, 1'b1); step();
    in_valid = 1'b0;
    chk("postrst_data", out_data, 8'h22);
    chk("postrst_valid", out_valid, 1);
    step();
    chk("postrst_drain", out_valid, 0);

    // random valid/ready traffic against a scoreboard
    accepted = 0; cyc = 0; hold_prev = 1'b0; hold_data = '0;
    while ((accepted < 10000 || q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (hold_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold_data) begin
          errors++;
          $display("FAIL rand_stall_hold: got valid %0b data %0h expected valid 1 data %0h",
                   out_valid, out_data, hold_data);
        end
      end
      in_valid  = (accepted < 10000) && ($urandom_range(3) != 0);
      sel       = 2'($urandom);
      en        = ($urandom_range(4) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(3) != 0);
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_beat: got data %0h expected no beat", out_data);
        end else begin
          exp_beat = q.pop_front();
          if ({out_data, out_err} !== exp_beat) begin
            errors++;
            $display("FAIL rand_beat: got %0h/%0b expected %0h/%0b",
                     out_data, out_err, exp_beat[8:1], exp_beat[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({(en ? in_data[sel*8 +: 8] : 8'h00), 1'b0});
        accepted++;
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end
    in_valid = 1'b0;
    chk("rand_complete", 32'((accepted == 10000) && (q.size() == 0)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
